// File: rtl/imem_loader.sv
// Instruction-memory loader: 16-bit word count then little-endian 32-bit words from a byte stream.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte before DONE.
module imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  tb_rst,
   input  logic                  start,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  cpu_hold
);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   state_t      state;
   logic [7:0]  len_lo;
   logic [15:0] n_words;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] word_buf;
   logic [7:0]  csum;
   logic [15:0] len_word;
   logic        accept;
   logic        len_bad;
   logic        last_word;

   assign accept    = s_valid & s_ready;
   assign len_word  = {s_data, len_lo};
   assign len_bad   = (len_word == 16'd0) || ({1'b0, len_word} > MAX_WORDS);
   assign last_word = (word_idx == n_words - 16'd1);

`ifndef IMEM_LOADER_CSUM_EN
   logic unused_csum;
   assign unused_csum = ^csum;
`endif

   // Control state and registered outputs
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state    <= IDLE;
         s_ready  <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cpu_hold <= 1'b1;
         word_idx <= '0;
         byte_idx <= '0;
         csum     <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state    <= LEN_LO;
                  s_ready  <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
                  word_idx <= '0;
                  byte_idx <= '0;
                  csum     <= '0;
               end
            end
            LEN_LO: begin
               if (accept) state <= LEN_HI;
            end
            LEN_HI: begin
               if (accept) begin
                  if (len_bad) begin
                     state   <= ERR;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                     err     <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  csum     <= csum ^ s_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                     wr_data  <= {s_data, word_buf};
                     word_idx <= word_idx + 16'd1;
                     if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state <= CSUM;
`else
                        state    <= DONE;
                        s_ready  <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
               if (accept) begin
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  if (s_data == csum) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Data capture needs no reset: every field is written before it is read
   always_ff @(posedge clk) begin
      if (state == LEN_LO && accept) len_lo <= s_data;
      if (state == LEN_HI && accept) n_words <= len_word;
      if (state == DATA && accept) begin
         case (byte_idx)
            2'd0:    word_buf[7:0]   <= s_data;
            2'd1:    word_buf[15:8]  <= s_data;
            2'd2:    word_buf[23:16] <= s_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of length/data cases plus hand-written multi-cycle sequences.
// Works with or without IMEM_LOADER_CSUM_EN defined.
module tb_imem_loader;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          tb_rst, start, s_valid, s_ready, wr_en, busy, done, err, cpu_hold;
   logic [7:0]    s_data;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;

   int checks   = 0;
   int failures = 0;
   bit stalled  = 1'b0;

   logic [7:0]    tx[$];
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   logic [AW-1:0] got_addr[$];
   logic [31:0]   got_data[$];
   int            gap_pat[7] = '{0, 2, 1, 0, 3, 1, 2};

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      int         nwords;
      logic [7:0] seed;
      bit         exp_err;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .tb_rst(tb_rst), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
   );

   always @(negedge clk) begin
      if (wr_en) begin
         got_addr.push_back(wr_addr);
         got_data.push_back(wr_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk_status(input string tag, input bit e_busy, input bit e_done,
                             input bit e_err, input bit e_hold, input bit e_ready);
      chk1({tag, ".busy"}, busy, e_busy);
      chk1({tag, ".done"}, done, e_done);
      chk1({tag, ".err"}, err, e_err);
      chk1({tag, ".cpu_hold"}, cpu_hold, e_hold);
      chk1({tag, ".s_ready"}, s_ready, e_ready);
   endtask

   task automatic clear_queues();
      tx.delete();
      exp_addr.delete();
      exp_data.delete();
      got_addr.delete();
      got_data.delete();
   endtask

   // Length bytes, nwords data words (counting pattern from seed, or all 0xFF), optional checksum
   task automatic build_load(input logic [7:0] lo, input logic [7:0] hi, input int nwords,
                             input logic [7:0] seed, input bit fill_ff, input bit bad_csum);
      logic [7:0]  b;
      logic [7:0]  x;
      logic [31:0] w;
      clear_queues();
      tx.push_back(lo);
      tx.push_back(hi);
      x = 8'h00;
      for (int i = 0; i < nwords; i++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            b = fill_ff ? 8'hFF : seed + 8'(4 * i + j);
            x = x ^ b;
            w[8*j +: 8] = b;
            tx.push_back(b);
         end
         exp_addr.push_back(AW'(i));
         exp_data.push_back(w);
      end
`ifdef IMEM_LOADER_CSUM_EN
      if (nwords > 0) tx.push_back(bad_csum ? x ^ 8'h01 : x);
`else
      if (bad_csum) x = 8'h00;
`endif
   endtask

   task automatic build_two(input logic [7:0] cs);
      logic [7:0] bytes[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      clear_queues();
      foreach (bytes[i]) tx.push_back(bytes[i]);
`ifdef IMEM_LOADER_CSUM_EN
      tx.push_back(cs);
`else
      if (cs == 8'h00) tx.push_back(8'h00);
`endif
      exp_addr.push_back(AW'(0));
      exp_addr.push_back(AW'(1));
      exp_data.push_back(32'h12345678);
      exp_data.push_back(32'hDEADBEEF);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
      int k;
      if (stalled) return;
      repeat (gap) begin
         @(negedge clk);
         s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      start   = with_start;
      k = 0;
      while (s_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      if (s_ready !== 1'b1) begin
         checks++;
         failures++;
         stalled = 1'b1;
         $display("FAIL send_byte.timeout s_ready=%b required=1 byte=%h", s_ready, b);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input bit use_gaps, input int start_at);
      stalled = 1'b0;
      for (int i = first; i <= last && i < tx.size(); i++)
         send_byte(tx[i], use_gaps ? gap_pat[i % 7] : 0, i == start_at);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL %s.idle_timeout busy=%b required=0", tag, busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, ".write_count"}, 32'(got_data.size()), 32'(exp_data.size()));
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         chk($sformatf("%s.addr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
         chk($sformatf("%s.data[%0d]", tag, i), got_data[i], exp_data[i]);
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{lo: 8'h00, hi: 8'h00, nwords: 0, seed: 8'h00, exp_err: 1'b1};
      vecs[1] = '{lo: 8'h01, hi: 8'h04, nwords: 0, seed: 8'h00, exp_err: 1'b1};
      vecs[2] = '{lo: 8'h01, hi: 8'h00, nwords: 1, seed: 8'h10, exp_err: 1'b0};
      vecs[3] = '{lo: 8'h03, hi: 8'h00, nwords: 3, seed: 8'hA0, exp_err: 1'b0};
      vecs[4] = '{lo: 8'h05, hi: 8'h00, nwords: 5, seed: 8'hF0, exp_err: 1'b0};

      tb_rst  = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;

      // Reset state, sampled during and after a 200 ns reset
      #150;
      chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk1("rst.wr_en", wr_en, 1'b0);
      chk("rst.wr_addr", 32'(wr_addr), 32'h0);
      chk("rst.wr_data", wr_data, 32'h0);
      #50 tb_rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Two-word reference load
      build_two(8'h2A);
      pulse_start();
      chk_status("two.start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      send_range(0, tx.size() - 1, 1'b0, -1);
      wait_idle("two");
      chk_status("two.end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("two");
`ifndef IMEM_LOADER_CSUM_EN
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h55;
      repeat (3) begin
         @(negedge clk);
         chk1("no_csum.extra_ready", s_ready, 1'b0);
      end
      s_valid = 1'b0;
      chk("no_csum.extra_writes", 32'(got_data.size()), 32'd2);
      chk1("no_csum.done_kept", done, 1'b1);
`endif

      foreach (vecs[v]) begin
         build_load(vecs[v].lo, vecs[v].hi, vecs[v].nwords, vecs[v].seed, 1'b0, 1'b0);
         pulse_start();
         chk_status($sformatf("vec%0d.start", v), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
         send_range(0, tx.size() - 1, 1'b0, -1);
         wait_idle($sformatf("vec%0d", v));
         chk_status($sformatf("vec%0d.end", v), 1'b0, !vecs[v].exp_err, vecs[v].exp_err,
                    vecs[v].exp_err, 1'b0);
         check_writes($sformatf("vec%0d", v));
      end

      // Full 1024-word load of 0xFF, back-to-back
      build_load(8'h00, 8'h04, 1024, 8'h00, 1'b1, 1'b0);
      pulse_start();
      send_range(0, tx.size() - 1, 1'b0, -1);
      wait_idle("full");
      chk_status("full.end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("full");
      if (got_addr.size() > 0) begin
         chk("full.last_addr", 32'(got_addr[got_addr.size() - 1]), 32'h3FF);
         chk("full.last_data", got_data[got_data.size() - 1], 32'hFFFFFFFF);
      end

      // Valid gaps plus an ignored start pulse in the middle of DATA
      build_two(8'h2A);
      pulse_start();
      send_range(0, tx.size() - 1, 1'b1, 5);
      wait_idle("gaps");
      chk_status("gaps.end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("gaps");

      // Asynchronous reset in the middle of word 1 of a three-word load
      build_load(8'h03, 8'h00, 3, 8'h40, 1'b0, 1'b0);
      pulse_start();
      send_range(0, 7, 1'b0, -1);
      chk1("rst_mid.busy_before", busy, 1'b1);
      #2 tb_rst = 1'b1;
      #1;
      chk_status("rst_mid.async", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk1("rst_mid.wr_en", wr_en, 1'b0);
      repeat (3) @(negedge clk);
      tb_rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid.write_count", 32'(got_data.size()), 32'd1);
      if (got_data.size() > 0) chk("rst_mid.word0", got_data[0], 32'h43424140);
      build_two(8'h2A);
      pulse_start();
      send_range(0, tx.size() - 1, 1'b0, -1);
      wait_idle("fresh");
      chk_status("fresh.end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("fresh");

`ifdef IMEM_LOADER_CSUM_EN
      // Wrong checksum byte: words still written, load fails
      build_two(8'h2B);
      pulse_start();
      send_range(0, tx.size() - 1, 1'b0, -1);
      wait_idle("bad_csum");
      chk_status("bad_csum.end", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_writes("bad_csum");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
